load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory stage directly downstream of the RV32I single-cycle core's ALU/register read.
- Takes the effective address (ALU result), store data (rs2 value) and funct3 for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Runs a request/ready transaction on a word-wide external data memory.
- Returns a sign/zero-extended load value for the core's memory_out writeback leg. Stalls the core while the access is in flight.

Parameters:
TIMEOUT, 16, max REQ cycles waiting for mem_ready before abort with error; 0 disables timeout
CNT_W, 5, width of timeout counter; must hold TIMEOUT

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
ls_valid  input  1  core presents a load/store this cycle
ls_store  input  1  1 = store, 0 = load
funct3  input  3  RV32I funct3 of the load/store
addr  input  32  effective byte address (ALU output)
wdata  input  32  store data (rs2 value)
ls_stall  output  1  core must hold PC/writeback this cycle
ls_done  output  1  one-cycle pulse: access complete, rdata/ls_err valid
ls_err  output  1  valid with ls_done: misaligned, illegal funct3 or timeout
rdata  output  32  formatted load result (0 for stores/errors)
mem_req  output  1  bus request, held until mem_ready
mem_we  output  1  1 = write
mem_addr  output  32  word address ({addr[31:2],2'b00})
mem_wstrb  output  4  byte write enables
mem_wdata  output  32  lane-replicated write data
mem_ready  input  1  memory accepts/completes this cycle (read data valid same cycle)
mem_rdata  input  32  read word

Behaviour:
- Clock port clk. Reset port reset, asynchronous and active-high. On reset: state IDLE; mem_req, mem_we, mem_wstrb, ls_done, ls_err = 0; mem_addr, mem_wdata, rdata = 0; counter = 0. Reset mid-transaction drops mem_req immediately and discards the access.
- FSM states: IDLE, REQ, DONE.
- IDLE: on ls_valid, latch ls_store, funct3, addr[1:0], wdata.
  - Legal and aligned: next state REQ. Register mem_req=1, mem_we=ls_store, mem_addr, mem_wstrb, mem_wdata.
  - Illegal funct3 (load 011/110/111; store 011..111) or misaligned (H: addr[0]!=0; W: addr[1:0]!=0): next state DONE with ls_err=1 and rdata=0. No bus request is issued.
- REQ: mem_req held with all bus fields stable.
  - When mem_ready=1: capture mem_rdata into formatted rdata (loads) or 0 (stores), drop mem_req, go to DONE with ls_err=0.
  - Counter increments each REQ cycle without ready. If TIMEOUT!=0 and the TIMEOUT-th REQ cycle passes without ready: drop mem_req, go to DONE with ls_err=1, rdata=0.
- DONE: ls_done=1 for exactly this cycle. Unconditional return to IDLE. ls_valid is ignored in DONE.
- ls_stall (combinational) = (IDLE & ls_valid) | REQ. It is low in DONE so the core commits that cycle.
- Minimum latency: ls_valid in IDLE at cycle 0 with mem_ready tied high gives mem_req at cycle 1, ls_done at cycle 2.
- Store strobes/data (o = addr[1:0]):
  - SB: wstrb = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<o, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = wdata.
- Loads: shifted = mem_rdata >> (8*o).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: mem_rdata.
- rdata holds its value until the next DONE. ls_err is valid only with ls_done and is cleared otherwise.
- mem_wstrb=0 on loads. mem_ready outside REQ is ignored.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, ready high -> mem_addr=0x100, mem_we=0, ls_done at cycle 2, rdata=0xDEADBEEF, ls_err=0, ls_stall high cycles 0-1.
- LB/LBU at addr=0x203, mem_rdata=0x80112233 -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080. LH at 0x202 -> 0xFFFF8011.
- SB addr=0x11, wdata=0x000000A5 -> mem_addr=0x10, wstrb=4'b0010, mem_wdata=0xA5A5A5A5, mem_we=1. SH addr=0x12, wdata=0x1234 -> wstrb=4'b1100, mem_wdata=0x12341234.
- Misaligned LW addr=0x102, then store funct3=3'b100 -> mem_req never asserts, ls_done+ls_err one cycle after ls_valid, rdata=0.
- mem_ready held low, TIMEOUT=16 -> mem_req high 16 cycles with stable fields, then drops. ls_done+ls_err next cycle. With ready on REQ cycle 5, normal completion, ls_err=0.
- Assert reset during REQ -> mem_req, ls_stall fall combinationally at reset. After release, a new LW completes normally with no stale ls_done.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage for an RV32I core.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW over a word-wide request/ready memory bus.
// While an access is in flight the core is stalled. The unit then returns a
// sign- or zero-extended load value together with a one-cycle done pulse.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        ls_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ls_stall,
  output logic        ls_done,
  output logic        ls_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        f3_q, f3_nxt;
  logic [1:0]        off_q, off_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              mem_req_nxt, mem_we_nxt, ls_err_nxt;
  logic [31:0]       mem_addr_nxt, mem_wdata_nxt, rdata_nxt;
  logic [3:0]        mem_wstrb_nxt;

  // funct3 must be a defined load/store encoding and the address naturally aligned
  function automatic logic is_legal(input logic st, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok_f3, aligned;
    if (st) ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    case (f3[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return ok_f3 && aligned;
  endfunction

  // byte enables for the addressed lanes
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // replicate narrow store data across all lanes so the strobes pick the right one
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // shift the addressed lane down and extend to 32 bits
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // stall while a request is being accepted or is outstanding; released during reset
  always_comb begin
    ls_stall = ~reset & (((state == IDLE) & ls_valid) | (state == REQ));
    ls_done  = (state == DONE);
  end

  // next-state and next-register values for the IDLE/REQ/DONE sequencer
  always_comb begin
    state_nxt     = state;
    f3_nxt        = f3_q;
    off_nxt       = off_q;
    cnt_nxt       = cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wstrb_nxt = mem_wstrb;
    mem_wdata_nxt = mem_wdata;
    rdata_nxt     = rdata;
    ls_err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (ls_valid) begin
          f3_nxt  = funct3;
          off_nxt = addr[1:0];
          if (is_legal(ls_store, funct3, addr[1:0])) begin
            state_nxt     = REQ;
            cnt_nxt       = '0;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = ls_store;
            mem_addr_nxt  = {addr[31:2], 2'b00};
            mem_wstrb_nxt = ls_store ? store_strb(funct3, addr[1:0]) : 4'b0000;
            mem_wdata_nxt = ls_store ? store_lanes(funct3, wdata) : 32'd0;
          end else begin
            state_nxt  = DONE;
            ls_err_nxt = 1'b1;
            rdata_nxt  = 32'd0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_nxt     = DONE;
          rdata_nxt     = mem_we ? 32'd0 : load_fmt(f3_q, off_q, mem_rdata);
          mem_req_nxt   = 1'b0;
          mem_we_nxt    = 1'b0;
          mem_wstrb_nxt = 4'b0000;
        end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
          state_nxt     = DONE;
          ls_err_nxt    = 1'b1;
          rdata_nxt     = 32'd0;
          mem_req_nxt   = 1'b0;
          mem_we_nxt    = 1'b0;
          mem_wstrb_nxt = 4'b0000;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state and bus/result registers; reset discards any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
      ls_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      f3_q      <= f3_nxt;
      off_q     <= off_nxt;
      cnt       <= cnt_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wstrb <= mem_wstrb_nxt;
      mem_wdata <= mem_wdata_nxt;
      rdata     <= rdata_nxt;
      ls_err    <= ls_err_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan accesses followed by random
// accesses, all checked against a behavioural model of the load/store rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid, ls_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        ls_stall, ls_done, ls_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_rd = 32'd0;

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_store(ls_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .ls_stall(ls_stall),
    .ls_done(ls_done), .ls_err(ls_err), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: access size in bytes from funct3, natural alignment,
  // lane data by replication, loads by shift/mask/extend.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mw,
                       output logic legal, output logic [3:0] strb,
                       output logic [31:0] lanes, output logic [31:0] ld);
    int nb;
    logic [31:0] mask, v;
    nb = 1 << f3[1:0];
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (legal && ((a % nb) != 0)) legal = 1'b0;
    strb  = st ? 4'(((1 << nb) - 1) << a[1:0]) : 4'd0;
    if (nb == 1)      lanes = wd[7:0] * 32'h01010101;
    else if (nb == 2) lanes = wd[15:0] * 32'h00010001;
    else              lanes = wd;
    mask = (nb >= 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = (mw >> (8 * a[1:0])) & mask;
    if (!f3[2] && nb < 4 && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    ld = v;
  endtask

  // One complete access; delay = REQ cycles before ready, negative = never ready.
  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mw, input int delay);
    logic legal, tmo, exp_err;
    logic [3:0]  strb;
    logic [31:0] lanes, ld, exp_rd;
    int ncyc;
    model(st, f3, a, wd, mw, legal, strb, lanes, ld);
    ls_valid = 1'b1; ls_store = st; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk("stall_idle_valid", ls_stall, 1);
    chk("done_idle", ls_done, 0);
    @(posedge clk); #1;
    ls_valid = 1'b0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (legal) begin
      tmo  = !(delay >= 0 && delay < TIMEOUT);
      ncyc = tmo ? TIMEOUT : delay + 1;
      for (int k = 1; k <= ncyc; k++) begin
        chk("req_high", mem_req, 1);
        chk("req_addr", mem_addr, {a[31:2], 2'b00});
        chk("req_we", mem_we, st);
        chk("req_wstrb", mem_wstrb, strb);
        if (st) chk("req_wdata", mem_wdata, lanes);
        chk("req_stall", ls_stall, 1);
        chk("req_done", ls_done, 0);
        chk("req_rdata_held", rdata, last_rd);
        mem_rdata = $urandom;
        if (!tmo && k == ncyc) begin
          mem_ready = 1'b1; mem_rdata = mw;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
      exp_err = tmo;
      exp_rd  = (tmo || st) ? 32'd0 : ld;
    end else begin
      exp_err = 1'b1;
      exp_rd  = 32'd0;
    end
    chk("done_pulse", ls_done, 1);
    chk("done_err", ls_err, exp_err);
    chk("done_rdata", rdata, exp_rd);
    chk("done_req_low", mem_req, 0);
    chk("done_stall_low", ls_stall, 0);
    last_rd = exp_rd;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    chk("after_done_low", ls_done, 0);
    chk("after_err_low", ls_err, 0);
    chk("after_rdata_held", rdata, last_rd);
    chk("after_req_low", mem_req, 0);
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ls_valid = 1'b0; ls_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", ls_done, 0);
    chk("rst_err", ls_err, 0);
    chk("rst_stall", ls_stall, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed test-plan accesses
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);   // LW
    run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0);   // LB
    run_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0);   // LBU
    run_op(1'b0, 3'b001, 32'h202, 32'h0, 32'h80112233, 0);   // LH
    run_op(1'b0, 3'b101, 32'h202, 32'h0, 32'h80112233, 2);   // LHU
    run_op(1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0, 0);    // SB
    run_op(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1);    // SH
    run_op(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0);    // SW
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0);   // misaligned LW
    run_op(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0);         // illegal store funct3
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);          // illegal load funct3
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0);          // misaligned LH
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111, -1);  // timeout
    run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'h22222222, 4);   // ready on REQ cycle 5
    run_op(1'b1, 3'b010, 32'h308, 32'h33333333, 32'h0, TIMEOUT - 1); // ready on last cycle

    // reset in the middle of an outstanding request
    ls_valid = 1'b1; ls_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    ls_valid = 1'b0;
    chk("mid_req_high", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_stall", ls_stall, 0);
    chk("rst_mid_done", ls_done, 0);
    chk("rst_mid_addr", mem_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd = 32'd0;
    @(posedge clk); #1;
    chk("post_rst_done", ls_done, 0);
    chk("post_rst_req", mem_req, 0);
    run_op(1'b0, 3'b010, 32'h600, 32'h0, 32'hA5A55A5A, 0);

    // random accesses
    for (int i = 0; i < 80; i++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] a;
      int d;
      st = 1'($urandom);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (st ? 3'($urandom_range(0, 2))
                                                            : 3'($urandom_range(0, 5)));
      a  = $urandom;
      d  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      run_op(st, f3, a, $urandom, $urandom, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
